// File: rtl/regfile_port_arb.sv
// Round-robin sharing of a 1W1R register file's read and write ports among NREQ requesters, with 3-cycle read-return routing.
// Optional macro REGFILE_ARB_RAW_ORDER_EN holds back writes that would land before an in-flight read of the same address.
module regfile_port_arb #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req_rvalid,
   input  logic [NREQ*ADDR_W-1:0] req_raddr,
   output logic [NREQ-1:0]        req_rready,
   input  logic [NREQ-1:0]        req_wvalid,
   input  logic [NREQ*ADDR_W-1:0] req_waddr,
   input  logic [NREQ*DATA_W-1:0] req_wdata,
   output logic [NREQ-1:0]        req_wready,
   output logic [NREQ-1:0]        resp_valid,
   output logic [DATA_W-1:0]      resp_data,
   output logic [ADDR_W-1:0]      rf_raddr0,
   output logic [ADDR_W-1:0]      rf_waddr,
   output logic [DATA_W-1:0]      rf_wdata,
   output logic                   rf_wena,
   input  logic [DATA_W-1:0]      rf_rdata0
);
   localparam int PW    = $clog2(NREQ);
   localparam int DEPTH = 3;

   function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] base, input int k);
      int s;
      s = int'(base) + k;
      if (s >= NREQ) s = s - NREQ;
      return PW'(s);
   endfunction

   logic [ADDR_W-1:0] raddr [NREQ];
   logic [ADDR_W-1:0] waddr [NREQ];
   logic [DATA_W-1:0] wdata [NREQ];

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign raddr[gi] = req_raddr[gi*ADDR_W +: ADDR_W];
      assign waddr[gi] = req_waddr[gi*ADDR_W +: ADDR_W];
      assign wdata[gi] = req_wdata[gi*DATA_W +: DATA_W];
   end

   logic [PW-1:0]    rptr, wptr, rptr_next, wptr_next;
   logic [NREQ-1:0]  rvalid_eff, wvalid_eff, wblock;
   logic             rhit, whit, bhit;
   logic [PW-1:0]    rwin, wwin, bfirst;
   logic [DEPTH-1:0] trk_valid;
   logic [PW-1:0]    trk_id [DEPTH];

   // Requests are masked during reset so no grant or write enable can escape.
   assign rvalid_eff = reset ? '0 : req_rvalid;
   assign wvalid_eff = reset ? '0 : req_wvalid;

   always_comb begin
      rhit = 1'b0;
      rwin = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!rhit && rvalid_eff[wrap_add(rptr, k)]) begin
            rhit = 1'b1;
            rwin = wrap_add(rptr, k);
         end
      end
   end

   assign req_rready = rhit ? (NREQ'(1) << rwin) : '0;
   assign rf_raddr0  = rhit ? raddr[rwin] : '0;
   assign rptr_next  = rhit ? wrap_add(rwin, 1) : rptr;

`ifdef REGFILE_ARB_RAW_ORDER_EN
   logic              prev_rhit;
   logic [ADDR_W-1:0] prev_raddr;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_rhit  <= 1'b0;
         prev_raddr <= '0;
      end else begin
         prev_rhit  <= rhit;
         prev_raddr <= rf_raddr0;
      end
   end

   // A read samples the array two edges after its grant, so writes to its address wait out that window.
   for (genvar gi = 0; gi < NREQ; gi++) begin : g_block
      assign wblock[gi] = (rhit && (waddr[gi] == rf_raddr0)) ||
                          (prev_rhit && (waddr[gi] == prev_raddr));
   end
`else
   assign wblock = '0;
`endif

   always_comb begin
      whit   = 1'b0;
      wwin   = '0;
      bhit   = 1'b0;
      bfirst = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!whit && wvalid_eff[wrap_add(wptr, k)]) begin
            if (wblock[wrap_add(wptr, k)]) begin
               if (!bhit) begin
                  bhit   = 1'b1;
                  bfirst = wrap_add(wptr, k);
               end
            end else begin
               whit = 1'b1;
               wwin = wrap_add(wptr, k);
            end
         end
      end
   end

   // A skipped (blocked) requester keeps the pointer so it retains priority once unblocked.
   assign wptr_next  = !whit ? wptr : (bhit ? bfirst : wrap_add(wwin, 1));
   assign req_wready = whit ? (NREQ'(1) << wwin) : '0;
   assign rf_wena    = whit;
   assign rf_waddr   = whit ? waddr[wwin] : '0;
   assign rf_wdata   = whit ? wdata[wwin] : '0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rptr      <= '0;
         wptr      <= '0;
         trk_valid <= '0;
         for (int s = 0; s < DEPTH; s++) trk_id[s] <= '0;
      end else begin
         rptr      <= rptr_next;
         wptr      <= wptr_next;
         trk_valid <= {trk_valid[DEPTH-2:0], rhit};
         trk_id[0] <= rwin;
         for (int s = 1; s < DEPTH; s++) trk_id[s] <= trk_id[s-1];
      end
   end

   assign resp_valid = trk_valid[DEPTH-1] ? (NREQ'(1) << trk_id[DEPTH-1]) : '0;
   assign resp_data  = trk_valid[DEPTH-1] ? rf_rdata0 : '0;

endmodule

// File: tb/tb_regfile_port_arb.sv
// Self-checking bench for regfile_port_arb: directed scenarios plus randomized traffic against a cycle-level reference model.
// Honours REGFILE_ARB_RAW_ORDER_EN when defined for the build.
module tb_regfile_port_arb;
   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 64;
`ifdef REGFILE_ARB_RAW_ORDER_EN
   localparam bit RAW = 1'b1;
   localparam int LAG = 0;
`else
   localparam bit RAW = 1'b0;
   localparam int LAG = 2;
`endif

   logic              clock = 1'b0;
   logic              reset;
   logic [NREQ-1:0]   req_rvalid, req_rready, req_wvalid, req_wready, resp_valid;
   logic [NREQ*AW-1:0] req_raddr, req_waddr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [DW-1:0]     resp_data, rf_wdata, rf_rdata0;
   logic [AW-1:0]     rf_raddr0, rf_waddr;
   logic              rf_wena;
   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   regfile_port_arb #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clock(clock), .reset(reset),
      .req_rvalid(req_rvalid), .req_raddr(req_raddr), .req_rready(req_rready),
      .req_wvalid(req_wvalid), .req_waddr(req_waddr), .req_wdata(req_wdata),
      .req_wready(req_wready), .resp_valid(resp_valid), .resp_data(resp_data),
      .rf_raddr0(rf_raddr0), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .rf_wena(rf_wena), .rf_rdata0(rf_rdata0)
   );

   // Register file with a 3-cycle read pipeline: address, address, array read.
   logic [DW-1:0] rf_mem [256];
   logic [AW-1:0] rf_a1, rf_a2;
   logic [DW-1:0] rf_dout;
   always @(posedge clock) begin
      if (rf_wena) rf_mem[rf_waddr] <= rf_wdata;
      rf_a1   <= rf_raddr0;
      rf_a2   <= rf_a1;
      rf_dout <= rf_mem[rf_a2];
   end
   assign rf_rdata0 = rf_dout;

   task automatic do_reset();
      req_rvalid = '0;
      req_wvalid = '0;
      reset      = 1'b1;
      @(posedge clock);
      @(posedge clock);
      #1 reset = 1'b0;
   endtask

   task automatic rf_write(input int id, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n;
      n = 0;
      req_wvalid[id]          = 1'b1;
      req_waddr[id*AW +: AW]  = a;
      req_wdata[id*DW +: DW]  = d;
      @(negedge clock);
      while (!req_wready[id] && n < 20) begin
         n++;
         @(negedge clock);
      end
      checks++;
      if (req_wready[id] !== 1'b1) begin
         failures++;
         $display("FAIL write_grant_timeout id=%0d got=%b exp=1", id, req_wready[id]);
      end
      @(posedge clock);
      #1 req_wvalid[id] = 1'b0;
   endtask

   task automatic test_reset();
      reset      = 1'b1;
      req_rvalid = '1;
      req_wvalid = '1;
      for (int n = 0; n < NREQ; n++) begin
         req_raddr[n*AW +: AW] = AW'(8'h11 * (n + 1));
         req_waddr[n*AW +: AW] = AW'(8'h22 * (n + 1));
         req_wdata[n*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(n);
      end
      @(negedge clock);
      checks += 8;
      if (req_rready !== '0) begin failures++; $display("FAIL rst_rready got=%b exp=0", req_rready); end
      if (req_wready !== '0) begin failures++; $display("FAIL rst_wready got=%b exp=0", req_wready); end
      if (rf_wena !== 1'b0) begin failures++; $display("FAIL rst_wena got=%b exp=0", rf_wena); end
      if (rf_raddr0 !== '0) begin failures++; $display("FAIL rst_raddr got=%h exp=0", rf_raddr0); end
      if (rf_waddr !== '0) begin failures++; $display("FAIL rst_waddr got=%h exp=0", rf_waddr); end
      if (rf_wdata !== '0) begin failures++; $display("FAIL rst_wdata got=%h exp=0", rf_wdata); end
      if (resp_valid !== '0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
      if (resp_data !== '0) begin failures++; $display("FAIL rst_resp_data got=%h exp=0", resp_data); end
      req_rvalid = '0;
      req_wvalid = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      checks += 4;
      if (req_rready !== '0) begin failures++; $display("FAIL idle_rready got=%b exp=0", req_rready); end
      if (req_wready !== '0) begin failures++; $display("FAIL idle_wready got=%b exp=0", req_wready); end
      if (resp_valid !== '0) begin failures++; $display("FAIL idle_resp_valid got=%b exp=0", resp_valid); end
      if (rf_wena !== 1'b0) begin failures++; $display("FAIL idle_wena got=%b exp=0", rf_wena); end
      @(posedge clock);
      #1;
   endtask

   task automatic test_write_read();
      do_reset();
      req_wvalid[1]       = 1'b1;
      req_waddr[AW +: AW] = 8'h10;
      req_wdata[DW +: DW] = 64'hDEAD_BEEF_0000_0001;
      @(negedge clock);
      checks += 4;
      if (req_wready !== 4'b0010) begin failures++; $display("FAIL wr_wready got=%b exp=0010", req_wready); end
      if (rf_wena !== 1'b1) begin failures++; $display("FAIL wr_wena got=%b exp=1", rf_wena); end
      if (rf_waddr !== 8'h10) begin failures++; $display("FAIL wr_waddr got=%h exp=10", rf_waddr); end
      if (rf_wdata !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL wr_wdata got=%h exp=deadbeef00000001", rf_wdata); end
      @(posedge clock);
      #1 req_wvalid = '0;
      @(posedge clock);
      #1;
      req_rvalid[2]         = 1'b1;
      req_raddr[2*AW +: AW] = 8'h10;
      @(negedge clock);
      checks += 2;
      if (req_rready !== 4'b0100) begin failures++; $display("FAIL rd_rready got=%b exp=0100", req_rready); end
      if (rf_raddr0 !== 8'h10) begin failures++; $display("FAIL rd_raddr got=%h exp=10", rf_raddr0); end
      @(posedge clock);
      #1 req_rvalid = '0;
      for (int c = 3; c <= 5; c++) begin
         @(negedge clock);
         checks++;
         if (c < 5) begin
            if (resp_valid !== '0) begin failures++; $display("FAIL rd_early_resp cyc=%0d got=%b exp=0", c, resp_valid); end
         end else begin
            if (resp_valid !== 4'b0100) begin failures++; $display("FAIL rd_resp_valid got=%b exp=0100", resp_valid); end
            checks++;
            if (resp_data !== 64'hDEAD_BEEF_0000_0001) begin failures++; $display("FAIL rd_resp_data got=%h exp=deadbeef00000001", resp_data); end
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_rotation();
      do_reset();
      for (int i = 0; i < NREQ; i++) rf_write(0, AW'(i), 64'(i));
      do_reset();
      req_rvalid = '1;
      for (int i = 0; i < NREQ; i++) req_raddr[i*AW +: AW] = AW'(i);
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         checks += 3;
         if (req_rready !== NREQ'(1 << (c % NREQ))) begin failures++; $display("FAIL rot_grant cyc=%0d got=%b exp=%b", c, req_rready, NREQ'(1 << (c % NREQ))); end
         if (rf_raddr0 !== AW'(c % NREQ)) begin failures++; $display("FAIL rot_raddr cyc=%0d got=%h exp=%h", c, rf_raddr0, AW'(c % NREQ)); end
         if (c >= 3) begin
            if (resp_valid !== NREQ'(1 << ((c - 3) % NREQ))) begin failures++; $display("FAIL rot_resp_id cyc=%0d got=%b exp=%b", c, resp_valid, NREQ'(1 << ((c - 3) % NREQ))); end
            checks++;
            if (resp_data !== 64'((c - 3) % NREQ)) begin failures++; $display("FAIL rot_resp_data cyc=%0d got=%h exp=%h", c, resp_data, 64'((c - 3) % NREQ)); end
         end else begin
            if (resp_valid !== '0) begin failures++; $display("FAIL rot_early_resp cyc=%0d got=%b exp=0", c, resp_valid); end
         end
         @(posedge clock);
         #1;
      end
      req_rvalid = '0;
   endtask

   task automatic test_reset_inflight();
      do_reset();
      req_rvalid[2]         = 1'b1;
      req_raddr[2*AW +: AW] = 8'h10;
      @(negedge clock);
      checks++;
      if (req_rready !== 4'b0100) begin failures++; $display("FAIL rif_grant got=%b exp=0100", req_rready); end
      @(posedge clock);
      #1;
      req_rvalid = '0;
      reset      = 1'b1;
      @(negedge clock);
      checks++;
      if (resp_valid !== '0) begin failures++; $display("FAIL rif_resp_in_reset got=%b exp=0", resp_valid); end
      @(posedge clock);
      #1 reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         checks++;
         if (resp_valid !== '0) begin failures++; $display("FAIL rif_stale_resp cyc=%0d got=%b exp=0", c, resp_valid); end
         @(posedge clock);
         #1;
      end
      req_rvalid = '1;
      for (int i = 0; i < NREQ; i++) req_raddr[i*AW +: AW] = AW'(i);
      @(negedge clock);
      checks++;
      if (req_rready !== 4'b0001) begin failures++; $display("FAIL rif_first_grant got=%b exp=0001", req_rready); end
      @(posedge clock);
      #1 req_rvalid = '0;
   endtask

   task automatic test_raw_order();
      logic [NREQ-1:0] exp_w;
      do_reset();
      rf_write(0, 8'h20, 64'h1);
      req_rvalid[0]         = 1'b1;
      req_raddr[0 +: AW]    = 8'h20;
      req_wvalid[3]         = 1'b1;
      req_waddr[3*AW +: AW] = 8'h20;
      req_wdata[3*DW +: DW] = 64'h2;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         exp_w = (c == (RAW ? 2 : 0)) ? 4'b1000 : 4'b0000;
         checks++;
         if (req_wready !== exp_w) begin failures++; $display("FAIL raw_wready cyc=%0d got=%b exp=%b", c, req_wready, exp_w); end
         if (c == 0) begin
            checks++;
            if (req_rready !== 4'b0001) begin failures++; $display("FAIL raw_rready got=%b exp=0001", req_rready); end
         end
         if (c == 3) begin
            checks += 2;
            if (resp_valid !== 4'b0001) begin failures++; $display("FAIL raw_resp_valid got=%b exp=0001", resp_valid); end
            if (resp_data !== (RAW ? 64'h1 : 64'h2)) begin failures++; $display("FAIL raw_resp_data got=%h exp=%h", resp_data, RAW ? 64'h1 : 64'h2); end
         end
         @(posedge clock);
         #1;
         req_rvalid[0] = 1'b0;
         if (exp_w[3]) req_wvalid[3] = 1'b0;
      end
      req_wvalid[3]      = 1'b0;
      req_rvalid[1]      = 1'b1;
      req_raddr[AW +: AW] = 8'h20;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (c == 3) begin
            checks += 2;
            if (resp_valid !== 4'b0010) begin failures++; $display("FAIL raw_reread_valid got=%b exp=0010", resp_valid); end
            if (resp_data !== 64'h2) begin failures++; $display("FAIL raw_reread_data got=%h exp=2", resp_data); end
         end
         @(posedge clock);
         #1 req_rvalid[1] = 1'b0;
      end
   endtask

   task automatic test_parallel();
      do_reset();
      for (int c = 0; c < 9; c++) begin
         if (c < 6) begin
            req_rvalid[1]         = 1'b1;
            req_raddr[AW +: AW]   = AW'(c % 4);
            req_wvalid[2]         = 1'b1;
            req_waddr[2*AW +: AW] = AW'(8'h50 + c);
            req_wdata[2*DW +: DW] = 64'(100 + c);
         end else begin
            req_rvalid = '0;
            req_wvalid = '0;
         end
         @(negedge clock);
         if (c < 6) begin
            checks += 4;
            if (req_rready !== 4'b0010) begin failures++; $display("FAIL par_rready cyc=%0d got=%b exp=0010", c, req_rready); end
            if (req_wready !== 4'b0100) begin failures++; $display("FAIL par_wready cyc=%0d got=%b exp=0100", c, req_wready); end
            if (rf_waddr !== AW'(8'h50 + c)) begin failures++; $display("FAIL par_waddr cyc=%0d got=%h exp=%h", c, rf_waddr, AW'(8'h50 + c)); end
            if (rf_wdata !== 64'(100 + c)) begin failures++; $display("FAIL par_wdata cyc=%0d got=%h exp=%h", c, rf_wdata, 64'(100 + c)); end
         end
         if (c >= 3) begin
            checks += 2;
            if (resp_valid !== 4'b0010) begin failures++; $display("FAIL par_resp_valid cyc=%0d got=%b exp=0010", c, resp_valid); end
            if (resp_data !== 64'((c - 3) % 4)) begin failures++; $display("FAIL par_resp_data cyc=%0d got=%h exp=%h", c, resp_data, 64'((c - 3) % 4)); end
         end
         @(posedge clock);
         #1;
      end
   endtask

   task automatic test_random();
      logic [DW-1:0]   mem_m [256];
      logic            pr_v [NREQ];
      logic [AW-1:0]   pr_a [NREQ];
      logic            pw_v [NREQ];
      logic [AW-1:0]   pw_a [NREQ];
      logic [DW-1:0]   pw_d [NREQ];
      logic            sv [8];
      int              sid [8];
      logic [AW-1:0]   sa [8];
      logic [DW-1:0]   sd [8];
      int              rptr_m, wptr_m, er, ew, fb, idx, slot;
      logic            prev_v, blk;
      logic [AW-1:0]   prev_a, exp_ra, exp_wa;
      logic [DW-1:0]   exp_wd, exp_rd;
      logic [NREQ-1:0] exp_rr, exp_wr, exp_rv;

      do_reset();
      for (int a = 0; a < 8; a++) begin
         mem_m[a] = {$urandom, $urandom};
         rf_write(a % NREQ, AW'(a), mem_m[a]);
      end
      do_reset();
      rptr_m = 0;
      wptr_m = 0;
      prev_v = 1'b0;
      prev_a = '0;
      for (int s = 0; s < 8; s++) sv[s] = 1'b0;
      for (int n = 0; n < NREQ; n++) begin
         pr_v[n] = 1'b0;
         pw_v[n] = 1'b0;
      end

      for (int c = 0; c < 1500; c++) begin
         for (int n = 0; n < NREQ; n++) begin
            if (!pr_v[n] && $urandom_range(0, 2) != 0) begin
               pr_v[n] = 1'b1;
               pr_a[n] = AW'($urandom_range(0, 7));
            end
            if (!pw_v[n] && $urandom_range(0, 2) == 0) begin
               pw_v[n] = 1'b1;
               pw_a[n] = AW'($urandom_range(0, 7));
               pw_d[n] = {$urandom, $urandom};
            end
            req_rvalid[n]         = pr_v[n];
            req_raddr[n*AW +: AW] = pr_v[n] ? pr_a[n] : AW'($urandom);
            req_wvalid[n]         = pw_v[n];
            req_waddr[n*AW +: AW] = pw_v[n] ? pw_a[n] : AW'($urandom);
            req_wdata[n*DW +: DW] = pw_v[n] ? pw_d[n] : {$urandom, $urandom};
         end
         @(negedge clock);

         // Reference grants: first valid requester at or after the pointer, wrapping.
         er = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (rptr_m + k) % NREQ;
            if (er < 0 && pr_v[idx]) er = idx;
         end
         ew = -1;
         fb = -1;
         for (int k = 0; k < NREQ; k++) begin
            idx = (wptr_m + k) % NREQ;
            if (ew < 0 && pw_v[idx]) begin
               blk = 1'b0;
               if (RAW && er >= 0 && pw_a[idx] == pr_a[er]) blk = 1'b1;
               if (RAW && prev_v && pw_a[idx] == prev_a) blk = 1'b1;
               if (blk) begin
                  if (fb < 0) fb = idx;
               end else begin
                  ew = idx;
               end
            end
         end
         exp_rr = '0; exp_ra = '0;
         exp_wr = '0; exp_wa = '0; exp_wd = '0;
         if (er >= 0) begin exp_rr = NREQ'(1) << er; exp_ra = pr_a[er]; end
         if (ew >= 0) begin exp_wr = NREQ'(1) << ew; exp_wa = pw_a[ew]; exp_wd = pw_d[ew]; end
         exp_rv = '0;
         exp_rd = '0;
         if (c >= 3 && sv[(c - 3) % 8]) begin
            exp_rv = NREQ'(1) << sid[(c - 3) % 8];
            exp_rd = sd[(c - 3) % 8];
         end

         checks += 8;
         if (req_rready !== exp_rr) begin failures++; $display("FAIL rand_rready cyc=%0d got=%b exp=%b", c, req_rready, exp_rr); end
         if (rf_raddr0 !== exp_ra) begin failures++; $display("FAIL rand_raddr cyc=%0d got=%h exp=%h", c, rf_raddr0, exp_ra); end
         if (req_wready !== exp_wr) begin failures++; $display("FAIL rand_wready cyc=%0d got=%b exp=%b", c, req_wready, exp_wr); end
         if (rf_wena !== (ew >= 0)) begin failures++; $display("FAIL rand_wena cyc=%0d got=%b exp=%b", c, rf_wena, ew >= 0); end
         if (rf_waddr !== exp_wa) begin failures++; $display("FAIL rand_waddr cyc=%0d got=%h exp=%h", c, rf_waddr, exp_wa); end
         if (rf_wdata !== exp_wd) begin failures++; $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", c, rf_wdata, exp_wd); end
         if (resp_valid !== exp_rv) begin failures++; $display("FAIL rand_resp_valid cyc=%0d got=%b exp=%b", c, resp_valid, exp_rv); end
         if (resp_data !== exp_rd) begin failures++; $display("FAIL rand_resp_data cyc=%0d got=%h exp=%h", c, resp_data, exp_rd); end

         slot     = c % 8;
         sv[slot] = (er >= 0);
         if (er >= 0) begin
            sid[slot] = er;
            sa[slot]  = pr_a[er];
         end
         // Read data is the array state after all writes granted up to LAG-1 cycles after the read.
         if (c >= LAG && sv[(c - LAG) % 8]) sd[(c - LAG) % 8] = mem_m[sa[(c - LAG) % 8]];

         @(posedge clock);
         #1;
         if (ew >= 0) begin
            mem_m[pw_a[ew]] = pw_d[ew];
            wptr_m = (fb >= 0) ? fb : (ew + 1) % NREQ;
            pw_v[ew] = 1'b0;
         end
         prev_v = (er >= 0);
         prev_a = exp_ra;
         if (er >= 0) begin
            rptr_m   = (er + 1) % NREQ;
            pr_v[er] = 1'b0;
         end
      end
      req_rvalid = '0;
      req_wvalid = '0;
   endtask

   initial begin
      reset      = 1'b1;
      req_rvalid = '0;
      req_wvalid = '0;
      req_raddr  = '0;
      req_waddr  = '0;
      req_wdata  = '0;
      test_reset();
      test_write_read();
      test_rotation();
      test_reset_inflight();
      test_raw_order();
      test_parallel();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/regfile_port_arb.md
# regfile_port_arb

Round-robin arbiter and sequencer that shares the single read port and single write port of the 256x64 1W1R register file among NREQ requesters. Accepts per-requester read/write requests with valid/ready handshakes, drives the register-file ports, tracks each read through the register file's fixed 3-cycle read pipeline, and routes returned data back to the requester that issued it. Sits between client engines and the register-file instance in the same clock domain.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 8, register address width (256 entries)
- DATA_W, 64, register data width
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_rvalid  in  NREQ  read request valid, one bit per requester
- req_raddr  in  NREQ*ADDR_W  read address; requester i uses bits [i*ADDR_W +: ADDR_W]
- req_rready  out  NREQ  read grant; handshake when rvalid[i] & rready[i]
- req_wvalid  in  NREQ  write request valid
- req_waddr  in  NREQ*ADDR_W  write address, packed as req_raddr
- req_wdata  in  NREQ*DATA_W  write data, packed per requester
- req_wready  out  NREQ  write grant
- resp_valid  out  NREQ  one-hot read-response strobe, single cycle
- resp_data  out  DATA_W  read data, valid when any resp_valid bit is set
- rf_raddr0  out  ADDR_W  to register file read address
- rf_waddr  out  ADDR_W  to register file write address
- rf_wdata  out  DATA_W  to register file write data
- rf_wena  out  1  to register file write enable
- rf_rdata0  in  DATA_W  from register file read data

## Operation
- Read and write arbitration are independent; each has its own round-robin pointer (rptr, wptr), both reset to 0.
- Each cycle at most one read grant: the first i with req_rvalid[i] searching from rptr upward modulo NREQ. req_rready is one-hot of the winner, all-zero if none. On grant, rptr <= winner+1 mod NREQ; otherwise rptr holds.
- rf_raddr0 = winner's address in the grant cycle. With no grant it is driven to 0; the resulting read is discarded.
- The write path uses the same rule with wptr. rf_wena = 1 only in a write-grant cycle. rf_waddr/rf_wdata carry the winner's fields and are 0 otherwise.
- Read tracking: 3-stage shift register of {valid, requester id}. Stage 0 loads on a read grant. At stage 3, resp_valid[id] = 1 and resp_data = rf_rdata0.
- There is no response backpressure. Requesters must sink resp_valid in the cycle it is asserted.
- Grants are combinational from the valid inputs and registered pointers. A requester must hold valid and address stable until it sees ready.
- Reset asserted at any time: pointers go to 0, all tracking stages are cleared, and in-flight reads produce no response. rf_wena is 0 while reset is high.
- Reset values: req_rready, req_wready, resp_valid, rf_wena are 0. resp_data, rf_raddr0, rf_waddr, rf_wdata are 0.

## Timing
- Read granted in cycle t produces resp_valid and resp_data in cycle t+3. Up to 3 reads can be in flight; sustained throughput is 1 read/cycle.
- A write granted in cycle t commits at the edge ending cycle t. It is visible to any read granted in cycle t-1 or later.
- A single requester holding valid continuously is granted every cycle.
- With all requesters valid, grants rotate 0,1,..,NREQ-1,0.

## Configuration
- REGFILE_ARB_RAW_ORDER_EN defined:
  - A read to address A granted in cycle t blocks any write to A in cycles t and t+1. The blocked write requester sees wready=0, and wptr does not advance past it.
  - Result: each read returns data as of writes granted strictly before it.
  - Writes to other addresses may still be granted in those cycles; the arbiter skips to the next eligible requester.
- REGFILE_ARB_RAW_ORDER_EN undefined:
  - No address comparison.
  - A read returns data including writes granted in its grant cycle and the cycle after.

## Test plan
- Reset, then all valids 0 -> all ready/resp outputs 0, rf_wena 0.
- Req1 writes 0xDEAD_BEEF_0000_0001 to addr 0x10 in cycle 0. Req2 reads 0x10 in cycle 2 -> resp_valid=4'b0100 with data 0xDEAD_BEEF_0000_0001 in cycle 5.
- All 4 requesters read continuously at addrs 0..3, each preloaded with value = addr -> grants rotate 0,1,2,3. Back-to-back responses arrive 3 cycles after each grant with matching id and data.
- Reset asserted 1 cycle after a read grant -> no resp_valid ever appears for that read. rptr returns to 0, so the first post-reset grant goes to requester 0.
- Addr 0x20 holds 0x1. Req0 reads 0x20 in cycle t while req3 writes 0x2 to 0x20 in cycle t:
  - With macro: write is stalled to cycle t+2 and the read returns 0x1.
  - Without macro: write is granted in cycle t and the read returns 0x2.
- Simultaneous read and write grants to different addresses in the same cycle both complete, at a throughput of 1 each per cycle.
